conv2_controller: RTL and testbench

CONV2_CONTROLLER -- requirements
Module: conv2_controller

---
 rtl/conv2_controller.sv | 149 ++++++++++++++
 tb/tb_conv2_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_controller.sv
// conv2_controller: sequences one conv2 layer pass (kernel width 2, 20 input
// channels, 10 output channels) over an IN_LEN-long feature buffer.
// Each output takes 22 cycles: 20 MAC cycles, one DRAIN cycle that absorbs the
// pipelined product, and one WRITE cycle that emits the saturated result.
// Optional macro CONV2_RELU_EN clamps negative results to zero on output.
module conv2_controller #(
  parameter int IN_LEN = 64,
  parameter int FRAC   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [3:0]         output_filter,
  output logic [4:0]         input_filter,
  input  logic signed [15:0] w0,
  input  logic signed [15:0] w1,
  output logic [7:0]         fm_t,
  output logic [4:0]         fm_ch,
  input  logic signed [15:0] fm_x0,
  input  logic signed [15:0] fm_x1,
  output logic               out_valid,
  output logic [7:0]         out_t,
  output logic [3:0]         out_ch,
  output logic signed [15:0] out_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;

  localparam logic [7:0] T_LAST  = 8'(IN_LEN - 2);
  localparam logic [4:0] IC_LAST = 5'd19;
  localparam logic [3:0] OC_LAST = 4'd9;

  state_t state_reg, state_next;

  logic [4:0]         ic_reg;
  logic [3:0]         oc_reg;
  logic [7:0]         t_reg;
  logic signed [32:0] p_reg;
  logic signed [39:0] acc_reg;

  logic               last_ic;
  logic               last_out;
  logic signed [32:0] prod_sum;
  logic signed [39:0] shifted;
  logic signed [15:0] sat_val;
  logic signed [15:0] res_val;

  assign last_ic  = (ic_reg == IC_LAST);
  assign last_out = (t_reg == T_LAST) && (oc_reg == OC_LAST);
  assign prod_sum = fm_x0 * w0 + fm_x1 * w1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MAC;
      MAC:     if (last_ic) state_next = DRAIN;
      DRAIN:   state_next = WRITE;
      WRITE:   state_next = last_out ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loop counters: ic steps through MAC, (t, oc) advance when a result is written.
  // Counters hold outside MAC so the memory addresses stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_reg <= '0;
      oc_reg <= '0;
      t_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            ic_reg <= '0;
            oc_reg <= '0;
            t_reg  <= '0;
          end
        end
        MAC: begin
          if (!last_ic) ic_reg <= ic_reg + 5'd1;
        end
        WRITE: begin
          if (!last_out) begin
            ic_reg <= '0;
            if (oc_reg == OC_LAST) begin
              oc_reg <= '0;
              t_reg  <= t_reg + 8'd1;
            end else begin
              oc_reg <= oc_reg + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Product pipeline register: one two-tap product per MAC cycle
  always_ff @(posedge clk) begin
    if (rst)                  p_reg <= '0;
    else if (state_reg == MAC) p_reg <= prod_sum;
  end

  // Accumulator: cleared on the first MAC cycle, then sums the 20 pipelined products
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (state_reg == MAC && ic_reg == 5'd0) begin
      acc_reg <= '0;
    end else if (state_reg == MAC || state_reg == DRAIN) begin
      acc_reg <= acc_reg + p_reg;
    end
  end

  // Output scaling: arithmetic shift, saturate to 16 bits, optional ReLU
  always_comb begin
    shifted = acc_reg >>> FRAC;
    sat_val = shifted[15:0];
    if (shifted > 40'sd32767)       sat_val = 16'sh7FFF;
    else if (shifted < -40'sd32768) sat_val = 16'sh8000;
`ifdef CONV2_RELU_EN
    res_val = sat_val[15] ? 16'sd0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  assign output_filter = oc_reg;
  assign input_filter  = ic_reg;
  assign fm_ch         = ic_reg;
  assign fm_t          = t_reg;
  assign out_t         = t_reg;
  assign out_ch        = oc_reg;
  assign out_valid     = (state_reg == WRITE);
  assign out_data      = (state_reg == WRITE) ? res_val : 16'sd0;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_conv2_controller.sv
// Self-checking bench for conv2_controller: memory models answer the DUT's
// addresses, a reference model fills a scoreboard, and a monitor checks writes
// and done latency.
module tb_conv2_controller;
  localparam int IN_LEN   = 4;
  localparam int FRAC     = 8;
  localparam int EXP_DONE = (IN_LEN - 1) * 220 + 1;

  logic               clk, rst, start;
  logic [3:0]         output_filter;
  logic [4:0]         input_filter;
  logic signed [15:0] w0, w1;
  logic [7:0]         fm_t;
  logic [4:0]         fm_ch;
  logic signed [15:0] fm_x0, fm_x1;
  logic               out_valid;
  logic [7:0]         out_t;
  logic [3:0]         out_ch;
  logic signed [15:0] out_data;
  logic               busy, done;

  conv2_controller #(.IN_LEN(IN_LEN), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .output_filter(output_filter), .input_filter(input_filter),
    .w0(w0), .w1(w1), .fm_t(fm_t), .fm_ch(fm_ch),
    .fm_x0(fm_x0), .fm_x1(fm_x1),
    .out_valid(out_valid), .out_t(out_t), .out_ch(out_ch), .out_data(out_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the DUT
  logic signed [15:0] xm  [0:IN_LEN-1][0:19];
  logic signed [15:0] wm0 [0:9][0:19];
  logic signed [15:0] wm1 [0:9][0:19];

  // Combinational weight memory and feature buffer
  always_comb begin
    fm_x0 = '0;
    fm_x1 = '0;
    w0    = '0;
    w1    = '0;
    if (int'(fm_t) < IN_LEN - 1 && int'(fm_ch) < 20) begin
      fm_x0 = xm[int'(fm_t)][int'(fm_ch)];
      fm_x1 = xm[int'(fm_t) + 1][int'(fm_ch)];
    end
    if (int'(output_filter) < 10 && int'(input_filter) < 20) begin
      w0 = wm0[int'(output_filter)][int'(input_filter)];
      w1 = wm1[int'(output_filter)][int'(input_filter)];
    end
  end

  typedef struct {int t; int ch; int data;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, longint act, longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  // Reference: plain dot product over channels and taps, then scale/saturate
  function automatic int ref_out(int t, int oc);
    longint acc = 0;
    longint v;
    for (int ic = 0; ic < 20; ic++)
      acc += longint'(xm[t][ic]) * longint'(wm0[oc][ic])
           + longint'(xm[t+1][ic]) * longint'(wm1[oc][ic]);
    v = acc >>> FRAC;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
`ifdef CONV2_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  function automatic void push_pass();
    exp_t e;
    for (int t = 0; t < IN_LEN - 1; t++)
      for (int oc = 0; oc < 10; oc++) begin
        e.t = t; e.ch = oc; e.data = ref_out(t, oc);
        sb.push_back(e);
      end
  endfunction

  function automatic logic signed [15:0] pick(int mode, bit is_w);
    case (mode)
      0:       return 16'($urandom_range(0, 1022) - 511);
      1:       return 16'($urandom);
      2:       return 16'sd256;
      3:       return 16'sd32767;
      4:       return is_w ? 16'sh8000 : 16'sd32767;
      5:       return is_w ? -16'sd256 : 16'sd256;
      default: return 16'sd0;
    endcase
  endfunction

  task automatic fill(int mode);
    for (int t = 0; t < IN_LEN; t++)
      for (int c = 0; c < 20; c++) xm[t][c] = pick(mode, 1'b0);
    for (int o = 0; o < 10; o++)
      for (int c = 0; c < 20; c++) begin
        wm0[o][c] = pick(mode, 1'b1);
        wm1[o][c] = pick(mode, 1'b1);
      end
  endtask

  // Monitor: pops the scoreboard on every write, times done from the start sample
  int  cnt   = 0;
  bit  armed = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (armed) cnt++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_t", out_t, e.t);
        check("out_ch", out_ch, e.ch);
        check("out_data", out_data, e.data);
      end
    end
    if (done) begin
      check("done_expected", armed, 1);
      if (armed) check("done_latency", cnt, EXP_DONE);
      armed = 1'b0;
    end
    if (rst) armed = 1'b0;
    else if (start && !busy) begin
      armed = 1'b1;
      cnt   = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(string name);
    for (int k = 0; k < EXP_DONE + 50; k++) begin
      if (done) break;
      step();
    end
    check({name, "_done_seen"}, done, 1);
  endtask

  task automatic run_pass(int mode, bit mid_start, bit addr_chk);
    int cyc;
    fill(mode);
    push_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    if (addr_chk) begin
      for (int k = 0; k < 20; k++) begin
        check("addr_input_filter", input_filter, k);
        check("addr_fm_ch", fm_ch, k);
        check("addr_output_filter", output_filter, 0);
        check("addr_fm_t", fm_t, 0);
        step();
        cyc++;
      end
      step(); step();
      cyc += 2;
      check("addr23_output_filter", output_filter, 1);
      check("addr23_input_filter", input_filter, 0);
    end
    if (mid_start) begin
      while (cyc < 50) begin step(); cyc++; end
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done("pass");
    step();
    check("sb_empty", sb.size(), 0);
    $display("pass mode=%0d complete", mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fill(6);
    step(); step(); step();
    rst = 1'b0;
    check("rst_output_filter", output_filter, 0);
    check("rst_input_filter", input_filter, 0);
    check("rst_fm_t", fm_t, 0);
    check("rst_fm_ch", fm_ch, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_t", out_t, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();

    run_pass(0, 1'b0, 1'b1);
    run_pass(2, 1'b0, 1'b0);
    run_pass(3, 1'b0, 1'b0);
    run_pass(4, 1'b0, 1'b0);
    run_pass(5, 1'b0, 1'b0);
    run_pass(1, 1'b1, 1'b0);

    // Reset in the middle of a pass
    fill(0);
    push_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (48) step();
    rst = 1'b1;
    step();
    sb.delete();
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_output_filter", output_filter, 0);
    check("mid_rst_input_filter", input_filter, 0);
    check("mid_rst_fm_t", fm_t, 0);
    check("mid_rst_done", done, 0);
    repeat (100) step();
    check("post_rst_idle", busy, 0);
    $display("mid-pass reset complete");

    // start held through DONE re-triggers from IDLE
    fill(0);
    push_pass();
    push_pass();
    start = 1'b1;
    step();
    wait_done("held1");
    step();
    check("held_idle_between", busy, 0);
    step();
    check("held_retrigger_busy", busy, 1);
    start = 1'b0;
    wait_done("held2");
    step();
    check("held_sb_empty", sb.size(), 0);
    $display("held-start re-trigger complete");

    run_pass(0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
